fpna_config_loader: RTL and testbench

//  Serial configuration loader for the neurochip fabric.
//  - Captures the bitstream from pins config_en / bs_in, one bit per clk while config_en is high.
//  - Checks the frame length and commits it atomically into the active configuration word.
//  - The fabric reads the active word; it never sees a partial load.
//  - Bits shifted past the local chain leave on bs_out, so chips can be daisy-chained.
//  - Sits between the uio pin mapping and the neuron/routing array.

---
 rtl/fpna_cfg_pkg.sv | 18 +
 rtl/fpna_sync.sv | 30 +++
 rtl/fpna_config_loader.sv | 133 +++++++++++++
 tb/tb_fpna_config_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpna_cfg_pkg.sv
// Shared types and helpers for the FPNA serial configuration loader.
// Holds the loader FSM encoding, the default word length and the counter sizing rule.
package fpna_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } cfg_state_t;

    localparam int CFG_BITS_DEFAULT = 80;

    // Room for 0..n+1 so the bit counter can saturate one past a full frame.
    function automatic int cnt_width(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/fpna_sync.sv
// Flop-chain synchroniser for raw pins.
// The output equals the input delayed by STAGES clocks.
module fpna_sync #(
    parameter int WIDTH  = 2,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fpna_config_loader.sv
// Serial configuration loader: shifts a bitstream in from the pins and commits
// the frame atomically into the active configuration word; overflow bits leave on bs_out.
module fpna_config_loader
    import fpna_cfg_pkg::*;
#(
    parameter int CFG_BITS    = CFG_BITS_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int ALLOW_CHAIN = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                config_en_pin,
    input  logic                bs_in_pin,
    output logic                bs_out,
    output logic [CFG_BITS-1:0] cfg_active,
    output logic                cfg_valid,
    output logic                cfg_commit,
    output logic                cfg_error,
    output logic                busy
);

    localparam int CW = cnt_width(CFG_BITS);
    localparam logic [CW-1:0] CNT_FULL = CW'(CFG_BITS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CFG_BITS + 1);

    logic [1:0] sync_out;
    logic       en_s;
    logic       bit_s;

    fpna_sync #(
        .WIDTH  (2),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({config_en_pin, bs_in_pin}),
        .q     (sync_out)
    );

    assign en_s  = sync_out[1];
    assign bit_s = sync_out[0];

    cfg_state_t          state_q, state_d;
    logic [CFG_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                bs_out_q, bs_out_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic                valid_q, valid_d;
    logic                commit_q, commit_d;
    logic                error_q, error_d;
    logic                frame_ok;

    // In chain mode the shift register holds the newest CFG_BITS bits of a longer frame.
    assign frame_ok = (ALLOW_CHAIN != 0) ? (cnt_q >= CNT_FULL) : (cnt_q == CNT_FULL);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        bs_out_d = bs_out_q;
        active_d = active_q;
        valid_d  = valid_q;
        commit_d = 1'b0;
        error_d  = error_q;

        if ((state_q == IDLE || state_q == SHIFT) && en_s) begin
            shift_d  = {shift_q[CFG_BITS-2:0], bit_s};
            bs_out_d = shift_q[CFG_BITS-1];
            cnt_d    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (en_s) begin
                    state_d = SHIFT;
                    cnt_d   = CW'(1);
                end
            end
            SHIFT: begin
                if (!en_s) begin
                    state_d = DONE;
                    if (frame_ok) begin
                        active_d = shift_q;
                        commit_d = 1'b1;
                        valid_d  = 1'b1;
                        error_d  = 1'b0;
                    end else begin
                        error_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                // Settling cycle: any bit presented now is deliberately dropped.
                state_d  = IDLE;
                bs_out_d = 1'b0;
                cnt_d    = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            bs_out_q <= 1'b0;
            active_q <= '0;
            valid_q  <= 1'b0;
            commit_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            bs_out_q <= bs_out_d;
            active_q <= active_d;
            valid_q  <= valid_d;
            commit_q <= commit_d;
            error_q  <= error_d;
        end
    end

    assign bs_out     = bs_out_q;
    assign cfg_active = active_q;
    assign cfg_valid  = valid_q;
    assign cfg_commit = commit_q;
    assign cfg_error  = error_q;
    assign busy       = (state_q == SHIFT) || (state_q == DONE);

endmodule

// File: tb/tb_fpna_config_loader.sv
// Scoreboard bench for fpna_config_loader: two instances (chain on/off) share the pins;
// frame-end monitors compare each finished window against queued expectations.
module tb_fpna_config_loader;

    localparam int NB = 16;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic bs;

    logic          bs_out1, valid1, commit1, error1, busy1;
    logic [NB-1:0] active1;
    logic          bs_out0, valid0, commit0, error0, busy0;
    logic [NB-1:0] active0;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic          commit;
        logic [NB-1:0] active;
        logic          error;
        logic          valid;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    always #5 clk = ~clk;

    fpna_config_loader #(.CFG_BITS(NB), .SYNC_STAGES(2), .ALLOW_CHAIN(1)) dut1 (
        .clk           (clk),
        .reset         (rst),
        .config_en_pin (en),
        .bs_in_pin     (bs),
        .bs_out        (bs_out1),
        .cfg_active    (active1),
        .cfg_valid     (valid1),
        .cfg_commit    (commit1),
        .cfg_error     (error1),
        .busy          (busy1)
    );

    fpna_config_loader #(.CFG_BITS(NB), .SYNC_STAGES(2), .ALLOW_CHAIN(0)) dut0 (
        .clk           (clk),
        .reset         (rst),
        .config_en_pin (en),
        .bs_in_pin     (bs),
        .bs_out        (bs_out0),
        .cfg_active    (active0),
        .cfg_valid     (valid0),
        .cfg_commit    (commit0),
        .cfg_error     (error0),
        .busy          (busy0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-end monitor for the chain-enabled instance.
    initial begin
        int   nc;
        logic pb;
        exp_t e;
        nc = 0;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                nc = 0;
                pb = 1'b0;
            end else begin
                if (commit1) nc++;
                if (pb && !busy1) begin
                    if (q1.size() == 0) begin
                        chk("chain1_unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        e = q1.pop_front();
                        $display("frame chain1: active=%h commits=%0d error=%b valid=%b",
                                 active1, nc, error1, valid1);
                        chk("chain1_commits", 32'(nc), 32'(e.commit));
                        chk("chain1_active", 32'(active1), 32'(e.active));
                        chk("chain1_error", 32'(error1), 32'(e.error));
                        chk("chain1_valid", 32'(valid1), 32'(e.valid));
                    end
                    nc = 0;
                end
                pb = busy1;
            end
        end
    end

    // Frame-end monitor for the exact-length instance.
    initial begin
        int   nc;
        logic pb;
        exp_t e;
        nc = 0;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                nc = 0;
                pb = 1'b0;
            end else begin
                if (commit0) nc++;
                if (pb && !busy0) begin
                    if (q0.size() == 0) begin
                        chk("exact0_unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        e = q0.pop_front();
                        $display("frame exact0: active=%h commits=%0d error=%b valid=%b",
                                 active0, nc, error0, valid0);
                        chk("exact0_commits", 32'(nc), 32'(e.commit));
                        chk("exact0_active", 32'(active0), 32'(e.active));
                        chk("exact0_error", 32'(error0), 32'(e.error));
                        chk("exact0_valid", 32'(valid0), 32'(e.valid));
                    end
                    nc = 0;
                end
                pb = busy0;
            end
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            en = 1'b0;
            bs = 1'b0;
        end
    endtask

    // Drives one window MSB first; optionally checks the daisy-chain output and
    // the commit latency of the chain-enabled instance.
    task automatic send(input logic [63:0] bits, input int n, input bit chain, input bit exp_c);
        logic [15:0] chain_word;
        chain_word = 16'h1234;
        for (int i = 0; i <= n + 3; i++) begin
            @(negedge clk);
            if (chain && i >= 19 && i < 35)
                chk("bs_out_chain", 32'(bs_out1), 32'(chain_word[34-i]));
            if (i == n + 2) chk("commit_early", 32'(commit1), 32'd0);
            if (i == n + 3) chk("commit_latency", 32'(commit1), 32'(exp_c));
            if (i < n) begin
                en = 1'b1;
                bs = bits[n-1-i];
            end else begin
                en = 1'b0;
                bs = 1'b0;
            end
        end
        idle(6);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        bs  = 1'b0;

        // Test 1: reset held while the pins toggle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en = i[0];
            bs = ~i[0];
        end
        chk("rst_active", 32'(active1), 32'd0);
        chk("rst_valid", 32'(valid1), 32'd0);
        chk("rst_commit", 32'(commit1), 32'd0);
        chk("rst_error", 32'(error1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_bs_out", 32'(bs_out1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        bs  = 1'b0;
        idle(4);

        // Test 2: clean 16-bit frame.
        q1.push_back('{1'b1, 16'hA5C3, 1'b0, 1'b1});
        q0.push_back('{1'b1, 16'hA5C3, 1'b0, 1'b1});
        send(64'hA5C3, 16, 1'b0, 1'b1);

        // Test 3: short frame is rejected, previous word kept.
        q1.push_back('{1'b0, 16'hA5C3, 1'b1, 1'b1});
        q0.push_back('{1'b0, 16'hA5C3, 1'b1, 1'b1});
        send(64'h7FFF, 15, 1'b0, 1'b0);

        // Test 4: 17-bit frame, accepted only with chaining.
        q1.push_back('{1'b1, 16'h5A5A, 1'b0, 1'b1});
        q0.push_back('{1'b0, 16'hA5C3, 1'b1, 1'b1});
        send(64'h1_5A5A, 17, 1'b0, 1'b1);

        // Test 5: 32-bit frame; the first word passes down the chain.
        q1.push_back('{1'b1, 16'hBEEF, 1'b0, 1'b1});
        q0.push_back('{1'b0, 16'hA5C3, 1'b1, 1'b1});
        send(64'h1234_BEEF, 32, 1'b1, 1'b1);

        // Test 6: reset in the middle of a window, then a fresh frame.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            en = 1'b1;
            bs = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        bs  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_active", 32'(active1), 32'd0);
        chk("midrst_valid", 32'(valid1), 32'd0);
        chk("midrst_busy", 32'(busy1), 32'd0);
        chk("midrst_error", 32'(error1), 32'd0);
        chk("midrst_active0", 32'(active0), 32'd0);
        chk("midrst_valid0", 32'(valid0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        q1.push_back('{1'b1, 16'h0F0F, 1'b0, 1'b1});
        q0.push_back('{1'b1, 16'h0F0F, 1'b0, 1'b1});
        send(64'h0F0F, 16, 1'b0, 1'b1);

        idle(4);
        chk("chain1_frames_left", 32'(q1.size()), 32'd0);
        chk("exact0_frames_left", 32'(q0.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
